backend_tx: RTL

//  Egress stage downstream of the frontend packet buffer. On a start pulse it reads

---
 rtl/backend_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/backend_tx.sv
// backend_tx: reads a packet from the buffer BRAM and streams it out as 256-bit AXI-Stream beats.
// A small prefetch FIFO hides BRAM read latency so beats flow back to back.
module backend_tx #(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         start,
  input  logic [15:0]  length_be,
  output logic         finish,
  output logic         busy,
  output logic         len_err,
  output logic         bram_enb,
  output logic [5:0]   bram_addrb,
  input  logic [255:0] bram_doutb,
  output logic [255:0] m_axis_tdata,
  output logic [31:0]  m_axis_tkeep,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] beats_q, beats_d, rd_ptr_q, rd_ptr_d, tx_cnt_q, tx_cnt_d, len_beats;
  logic [31:0] last_keep_q, last_keep_d;
  logic len_err_q, len_err_d;
  logic [RD_LATENCY-1:0] vld_q;
  logic [255:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0] in_flight;
  logic len_ok, issue, push, pop, empty, last_beat;

  assign len_beats = 7'((17'(length_be) + 17'd31) >> 5);
  assign len_ok = length_be != 16'd0 && length_be <= 16'd2048;
  assign empty = cnt_q == '0;
  assign push = vld_q[RD_LATENCY-1];
  assign pop = !empty && m_axis_tready;
  assign last_beat = tx_cnt_q == beats_q - 7'd1;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + {{CW{1'b0}}, vld_q[i]};
  end

  // Beat 0 is read in the start cycle itself; reads still in the BRAM pipeline reserve FIFO slots.
  assign issue = aresetn && (state_q == IDLE ? start && len_ok
                 : state_q == STREAM && rd_ptr_q < beats_q && {1'b0, cnt_q} + in_flight < DEPTH);

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    last_keep_d = last_keep_q;
    len_err_d = len_err_q;
    rd_ptr_d = issue ? rd_ptr_q + 7'd1 : rd_ptr_q;
    tx_cnt_d = pop ? tx_cnt_q + 7'd1 : tx_cnt_q;
    cnt_d = push && !pop ? cnt_q + CW'(1) : !push && pop ? cnt_q - CW'(1) : cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = len_ok ? STREAM : DONE;
        len_err_d = len_err_q | !len_ok;
        beats_d = len_beats;
        last_keep_d = length_be[4:0] == 5'd0 ? '1 : (32'h1 << length_be[4:0]) - 32'h1;
        rd_ptr_d = 7'd1;
        tx_cnt_d = '0;
      end
      STREAM: if (pop && last_beat) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      beats_q <= '0;
      rd_ptr_q <= '0;
      tx_cnt_q <= '0;
      last_keep_q <= '0;
      len_err_q <= 1'b0;
      vld_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      rd_ptr_q <= rd_ptr_d;
      tx_cnt_q <= tx_cnt_d;
      last_keep_q <= last_keep_d;
      len_err_q <= len_err_d;
      vld_q <= RD_LATENCY'({vld_q, issue});
      wr_q <= push ? (wr_q == AW'(FIFO_DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
      rd_q <= pop ? (rd_q == AW'(FIFO_DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge aclk) if (push) mem_q[wr_q] <= bram_doutb;

  assign finish = state_q == DONE;
  assign busy = state_q != IDLE;
  assign len_err = len_err_q;
  assign bram_enb = issue;
  assign bram_addrb = state_q == IDLE ? 6'd0 : rd_ptr_q[5:0];
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata = empty ? '0 : mem_q[rd_q];
  assign m_axis_tkeep = empty ? '0 : last_beat ? last_keep_q : '1;
  assign m_axis_tlast = !empty && last_beat;
endmodule
